// File: rtl/ram_bytelane_sync_pkg.sv
// Shared types and geometry helpers for the byte-lane synchronous RAM.
// The state enum and width functions are used by the top level and the lane arrays.
package ram_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAITST,
        ST_ACCESS
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int lane_w(input int data_w);
        return clog2(data_w / 8);
    endfunction

    function automatic int word_w(input int addr_w, input int data_w);
        return addr_w - lane_w(data_w);
    endfunction

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LANE_W = lane_w(DEF_DATA_W);
    localparam int DEF_WORD_W = word_w(DEF_ADDR_W, DEF_DATA_W);

endpackage

// File: rtl/ram_bytelane_sync_if.sv
// Request/acknowledge memory bus between a CPU-side requester and the byte-lane RAM.
// The requester drives the request fields; the RAM drives status and read data.
interface ram_bytelane_sync_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic              byte_op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              ready;
    logic              ack;
    logic              odd_err;
    logic [DATA_W-1:0] dout;
    logic              busy_clear;

    modport master (
        output req, we, byte_op, addr, din,
        input  ready, ack, odd_err, dout, busy_clear
    );

    modport slave (
        input  req, we, byte_op, addr, din,
        output ready, ack, odd_err, dout, busy_clear
    );
endinterface

// File: rtl/ram_bytelane_sync_lane.sv
// One 8-bit lane of the RAM: synchronous write, registered synchronous read.
// The read register only updates on a read strobe, so it holds between reads.
module ram_lane
    import ram_pkg::*;
#(
    parameter int AW = DEF_WORD_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [2**AW];
    logic [7:0] rdata_d;
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (ce && we) mem[addr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (ce && !we) rdata_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/ram_bytelane_sync.sv
// Parametrised byte-lane synchronous RAM with wait states, odd-address trap and
// a post-reset clear sequencer.
//
//   state     | meaning
//   ST_CLEAR  | zeroing word[clr_cnt] each cycle after reset
//   ST_IDLE   | ready, capturing the next request
//   ST_WAITST | burning WAIT cycles before the access
//   ST_ACCESS | single-cycle array access, ack or odd_err next cycle
module ram_bytelane_sync
    import ram_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int WAIT           = 0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic                clk,
    input logic                reset,
    ram_bytelane_sync_if.slave bus
);
    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = lane_w(DATA_W);
    localparam int WORD_W = word_w(ADDR_W, DATA_W);
    localparam int WAIT_W = 4;

    state_e              state_d, state_q;
    logic [WORD_W-1:0]   clr_cnt_d, clr_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_d, wait_cnt_q;
    logic [ADDR_W-1:0]   cap_addr_d, cap_addr_q;
    logic [DATA_W-1:0]   cap_din_d, cap_din_q;
    logic                cap_we_d, cap_we_q;
    logic                cap_byte_d, cap_byte_q;
    logic                ack_d, ack_q;
    logic                odd_err_d, odd_err_q;
    logic                rd_byte_d, rd_byte_q;
    logic [LANE_W-1:0]   rd_lane_d, rd_lane_q;

    logic [LANE_W-1:0]      cap_lane;
    logic [WORD_W-1:0]      cap_word;
    logic                   misaligned;
    logic [LANES-1:0]       lane_ce;
    logic [LANES-1:0]       lane_ce_g;
    logic                   lane_we;
    logic [WORD_W-1:0]      lane_addr;
    logic [LANES-1:0][7:0]  lane_wdata;
    logic [LANES-1:0][7:0]  lane_rdata;
    logic [DATA_W-1:0]      dout_fmt;

    assign cap_lane   = cap_addr_q[LANE_W-1:0];
    assign cap_word   = cap_addr_q[ADDR_W-1:LANE_W];
    assign misaligned = !cap_byte_q && (cap_lane != '0);

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        wait_cnt_d = wait_cnt_q;
        cap_addr_d = cap_addr_q;
        cap_din_d  = cap_din_q;
        cap_we_d   = cap_we_q;
        cap_byte_d = cap_byte_q;
        ack_d      = 1'b0;
        odd_err_d  = 1'b0;
        rd_byte_d  = rd_byte_q;
        rd_lane_d  = rd_lane_q;
        lane_ce    = '0;
        lane_we    = 1'b0;
        lane_addr  = cap_word;
        lane_wdata = '0;

        unique case (state_q)
            ST_CLEAR: begin
                lane_ce   = '1;
                lane_we   = 1'b1;
                lane_addr = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.req) begin
                    cap_addr_d = bus.addr;
                    cap_din_d  = bus.din;
                    cap_we_d   = bus.we;
                    cap_byte_d = bus.byte_op;
                    if (WAIT > 0) begin
                        state_d    = ST_WAITST;
                        wait_cnt_d = WAIT_W'(WAIT - 1);
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAITST: begin
                if (wait_cnt_q == '0) state_d = ST_ACCESS;
                else                  wait_cnt_d = wait_cnt_q - 1'b1;
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (misaligned) begin
                    odd_err_d = 1'b1;
                end else begin
                    ack_d   = 1'b1;
                    lane_we = cap_we_q;
                    if (cap_byte_q) lane_ce[cap_lane] = 1'b1;
                    else            lane_ce = '1;
                    // Byte writes replicate din[7:0]; only the enabled lane takes it.
                    for (int i = 0; i < LANES; i++) begin
                        lane_wdata[i] = cap_byte_q ? cap_din_q[7:0] : cap_din_q[8*i +: 8];
                    end
                    if (!cap_we_q) begin
                        rd_byte_d = cap_byte_q;
                        rd_lane_d = cap_lane;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt_q  <= '0;
            wait_cnt_q <= '0;
            cap_addr_q <= '0;
            cap_din_q  <= '0;
            cap_we_q   <= 1'b0;
            cap_byte_q <= 1'b0;
            ack_q      <= 1'b0;
            odd_err_q  <= 1'b0;
            rd_byte_q  <= 1'b0;
            rd_lane_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            cap_addr_q <= cap_addr_d;
            cap_din_q  <= cap_din_d;
            cap_we_q   <= cap_we_d;
            cap_byte_q <= cap_byte_d;
            ack_q      <= ack_d;
            odd_err_q  <= odd_err_d;
            rd_byte_q  <= rd_byte_d;
            rd_lane_q  <= rd_lane_d;
        end
    end

    // Reset must abort any pending access, including one landing on this edge.
    assign lane_ce_g = reset ? '0 : lane_ce;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ram_lane #(.AW(WORD_W)) u_lane (
            .clk   (clk),
            .reset (reset),
            .ce    (lane_ce_g[g]),
            .we    (lane_we),
            .addr  (lane_addr),
            .wdata (lane_wdata[g]),
            .rdata (lane_rdata[g])
        );
    end

    always_comb begin
        dout_fmt = lane_rdata;
        if (rd_byte_q) begin
            dout_fmt      = '0;
            dout_fmt[7:0] = lane_rdata[rd_lane_q];
        end
    end

    assign bus.ready      = (state_q == ST_IDLE) && !reset;
    assign bus.busy_clear = (state_q == ST_CLEAR);
    assign bus.ack        = ack_q;
    assign bus.odd_err    = odd_err_q;
    assign bus.dout       = dout_fmt;
endmodule

// File: tb/tb_ram_bytelane_sync.sv
// Self-checking bench: a 16-bit/WAIT=0 RAM and a 32-bit/WAIT=3 RAM checked
// against a byte-addressed memory model.
module tb_ram_bytelane_sync;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;

    ram_bytelane_sync_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
    ram_bytelane_sync_if #(.ADDR_W(10), .DATA_W(32)) bus1 ();

    ram_bytelane_sync #(.ADDR_W(16), .DATA_W(16), .WAIT(0), .CLEAR_ON_RESET(1'b1)) dut0 (
        .clk(clk), .reset(rst0), .bus(bus0));
    ram_bytelane_sync #(.ADDR_W(10), .DATA_W(32), .WAIT(3), .CLEAR_ON_RESET(1'b1)) dut1 (
        .clk(clk), .reset(rst1), .bus(bus1));

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  mem0 [int];
    logic [7:0]  mem1 [int];
    logic [63:0] last_dout [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o, expected %0o (octal)", tag, got, exp);
        end
    endtask

    function automatic int lanes_of(input int u);
        return (u == 0) ? 2 : 4;
    endfunction

    function automatic int mask_of(input int u);
        return (u == 0) ? 32'hFFFF : 32'h3FF;
    endfunction

    function automatic bit rdy(input int u);
        return (u == 0) ? bus0.ready : bus1.ready;
    endfunction

    function automatic bit get_ack(input int u);
        return (u == 0) ? bus0.ack : bus1.ack;
    endfunction

    function automatic bit get_err(input int u);
        return (u == 0) ? bus0.odd_err : bus1.odd_err;
    endfunction

    function automatic logic [63:0] get_dout(input int u);
        return (u == 0) ? 64'(bus0.dout) : 64'(bus1.dout);
    endfunction

    function automatic logic [7:0] mget(input int u, input int a);
        if (u == 0) return mem0.exists(a) ? mem0[a] : 8'h00;
        return mem1.exists(a) ? mem1[a] : 8'h00;
    endfunction

    function automatic void mput(input int u, input int a, input logic [7:0] v);
        if (u == 0) mem0[a] = v;
        else        mem1[a] = v;
    endfunction

    // Little-endian byte memory: byte address base+i sits in lane i.
    function automatic logic [63:0] model_read(input int u, input bit bo, input int a);
        logic [63:0] r;
        r = '0;
        if (bo) r[7:0] = mget(u, a);
        else for (int i = 0; i < lanes_of(u); i++) r[8*i +: 8] = mget(u, a + i);
        return r;
    endfunction

    function automatic void model_write(input int u, input bit bo, input int a, input logic [63:0] d);
        if (bo) mput(u, a, d[7:0]);
        else for (int i = 0; i < lanes_of(u); i++) mput(u, a + i, d[8*i +: 8]);
    endfunction

    task automatic drive(input int u, input bit r, input bit w, input bit bo,
                         input logic [15:0] a, input logic [63:0] d);
        if (u == 0) begin
            bus0.req = r; bus0.we = w; bus0.byte_op = bo; bus0.addr = a; bus0.din = d[15:0];
        end else begin
            bus1.req = r; bus1.we = w; bus1.byte_op = bo; bus1.addr = a[9:0]; bus1.din = d[31:0];
        end
    endtask

    task automatic xfer(input int u, input bit w, input bit bo, input logic [15:0] a,
                        input logic [63:0] d, output int lat, output bit ack_s,
                        output bit err_s, output logic [63:0] rd);
        int g;
        g = 0;
        while (!rdy(u) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("ready_timeout", 64'(rdy(u)), 64'd1);
        drive(u, 1'b1, w, bo, a, d);
        @(posedge clk);
        #1;
        drive(u, 1'b0, w, bo, a, d);
        lat = 0; ack_s = 1'b0; err_s = 1'b0;
        while (!ack_s && !err_s && lat < 40) begin
            @(negedge clk);
            lat++;
            ack_s = get_ack(u);
            err_s = get_err(u);
        end
        rd = get_dout(u);
        @(negedge clk);
        chk("pulse_width", 64'(get_ack(u) | get_err(u)), 64'd0);
    endtask

    task automatic op(input int u, input bit w, input bit bo, input logic [15:0] a,
                      input logic [63:0] d, input string tag);
        int lat;
        bit ack_s, err_s, odd;
        logic [63:0] rd, exp;
        int wt;
        wt  = (u == 0) ? 0 : 3;
        odd = !bo && ((int'(a) % lanes_of(u)) != 0);
        xfer(u, w, bo, a, d, lat, ack_s, err_s, rd);
        chk({tag, ":lat"}, 64'(lat), 64'(2 + wt));
        chk({tag, ":ack"}, 64'(ack_s), 64'(!odd));
        chk({tag, ":odd_err"}, 64'(err_s), 64'(odd));
        if (odd || w) begin
            chk({tag, ":dout_held"}, rd, last_dout[u]);
            if (!odd) model_write(u, bo, int'(a), d);
        end else begin
            exp = model_read(u, bo, int'(a));
            chk({tag, ":dout"}, rd, exp);
            last_dout[u] = exp;
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, acks, first;
        last_dout[0] = '0;
        last_dout[1] = '0;
        rst0 = 1'b1; rst1 = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);

        chk("rst_busy_clear", 64'(bus0.busy_clear), 64'd1);
        chk("rst_ready", 64'(bus0.ready), 64'd0);
        chk("rst_ack", 64'(bus0.ack), 64'd0);
        chk("rst_odd_err", 64'(bus0.odd_err), 64'd0);
        chk("rst_dout", 64'(bus0.dout), 64'd0);

        rst0 = 1'b0; rst1 = 1'b0;
        cnt = 0;
        while (bus0.busy_clear && cnt < 40000) begin
            cnt++;
            @(negedge clk);
        end
        chk("clear_cycles", 64'(cnt), 64'd32768);
        chk("clear_ready", 64'(bus0.ready), 64'd1);

        op(0, 1'b0, 1'b0, 16'o500, 64'd0, "rd500_cleared");
        chk("rd500_cleared_const", get_dout(0), 64'd0);
        op(0, 1'b1, 1'b0, 16'o500, 64'o012706, "wr500");
        op(0, 1'b0, 1'b0, 16'o500, 64'd0, "rd500");
        chk("rd500_const", get_dout(0), 64'o012706);
        op(0, 1'b1, 1'b1, 16'o501, 64'o377, "wrb501");
        op(0, 1'b0, 1'b1, 16'o501, 64'd0, "rdb501");
        chk("rdb501_const", get_dout(0), 64'o000377);
        op(0, 1'b0, 1'b0, 16'o500, 64'd0, "rd500_merge");
        chk("rd500_merge_const", get_dout(0), 64'o177706);
        op(0, 1'b1, 1'b0, 16'o503, 64'o123456, "wr503_odd");
        op(0, 1'b0, 1'b0, 16'o502, 64'd0, "rd502");
        chk("rd502_const", get_dout(0), 64'd0);

        // WAIT=3 read, with a stray request pulsed while the RAM is busy.
        drive(1, 1'b1, 1'b0, 1'b0, 16'h40, 64'd0);
        @(posedge clk);
        #1;
        bus1.req = 1'b0;
        acks = 0; first = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 2) bus1.req = 1'b1;
            if (c == 3) bus1.req = 1'b0;
            if (bus1.ack) begin
                acks++;
                if (first == 0) first = c;
            end
        end
        chk("wait3_lat", 64'(first), 64'd5);
        chk("wait3_ack_count", 64'(acks), 64'd1);
        chk("wait3_dout", get_dout(1), model_read(1, 1'b0, 32'h40));
        last_dout[1] = model_read(1, 1'b0, 32'h40);

        op(1, 1'b1, 1'b0, 16'h40, 64'h11223344, "w32_word");
        op(1, 1'b1, 1'b1, 16'h43, 64'hAB, "w32_lane3");
        op(1, 1'b0, 1'b0, 16'h40, 64'd0, "r32_word");
        chk("r32_lane3_const", get_dout(1), 64'hAB223344);

        // Reset during WAITST must abort the write and restart the clear.
        drive(1, 1'b1, 1'b1, 1'b0, 16'h80, 64'hDEADBEEF);
        @(posedge clk);
        #1;
        bus1.req = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk("abort_dout", get_dout(1), 64'd0);
        chk("abort_busy_clear", 64'(bus1.busy_clear), 64'd1);
        chk("abort_ready", 64'(bus1.ready), 64'd0);
        chk("abort_ack", 64'(bus1.ack), 64'd0);
        mem1.delete();
        last_dout[1] = '0;
        cnt = 0;
        while (bus1.busy_clear && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk("abort_clear_cycles", 64'(cnt), 64'd256);
        op(1, 1'b0, 1'b0, 16'h80, 64'd0, "rd_after_abort");
        chk("rd_after_abort_const", get_dout(1), 64'd0);

        for (int k = 0; k < 400; k++) begin
            int u;
            logic [15:0] a;
            bit bo, w;
            logic [63:0] d;
            u = k % 2;
            if ($urandom_range(0, 3) != 0) a = 16'($urandom_range(0, 31));
            else                           a = 16'($urandom) & 16'(mask_of(u));
            bo = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            if (!bo && $urandom_range(0, 7) != 0) a = a & ~16'(lanes_of(u) - 1);
            d = {$urandom, $urandom};
            op(u, w, bo, a, d, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
